// File: rtl/ad_dac_pkg.sv
// Shared definitions for the AD9708 transmit path: FSM encoding, config_dac
// field positions and the signed-zero (midscale) code.
package ad_dac_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } dac_state_e;

  localparam int CFG_OFS_EN_BIT = 31;
  localparam int CFG_FMT_TC_BIT = 30;
  localparam int MIN_DIV        = 2;

  // Offset-binary code for signed zero at a given sample width.
  function automatic logic [31:0] dac_midscale(input int w);
    return 32'h1 << (w - 1);
  endfunction
endpackage

// File: rtl/dac_sat_fmt.sv
// Offset add, saturation to the sample range and output format conversion.
// Purely combinational; the parent registers the result.
module dac_sat_fmt #(
  parameter int DAC_DATA_WIDTH = 12
) (
  input  logic [DAC_DATA_WIDTH-1:0] smp,
  input  logic [DAC_DATA_WIDTH-1:0] ofs,
  input  logic                      ofs_en,
  input  logic                      fmt_tc,
  output logic [DAC_DATA_WIDTH-1:0] code
);
  localparam int W = DAC_DATA_WIDTH;

  logic [W:0]   sum;
  logic [W-1:0] sat;

  always_comb begin
    sum = {smp[W-1], smp} + (ofs_en ? {ofs[W-1], ofs} : {(W+1){1'b0}});
    // The two top bits disagree only when the W+1-bit sum left the W-bit range.
    if (sum[W] != sum[W-1]) sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                    sat = sum[W-1:0];
    code = fmt_tc ? sat : {~sat[W-1], sat[W-2:0]};
  end
endmodule

// File: rtl/ad_9708_tx.sv
// AD9708 DAC transmitter: one-entry stream buffer, programmable sample period
// with a registered DAC latch clock, offset/saturate/format output path.
module ad_9708_tx
  import ad_dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 12,
  parameter bit UNDERFLOW_ZERO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [15:0]               div,
  input  logic [31:0]               config_dac,
  input  logic [DAC_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      dac_clk,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      underflow,
  output logic [15:0]               underflow_cnt
);
  localparam int              W        = DAC_DATA_WIDTH;
  localparam logic [31:0]     MID32    = dac_midscale(W);
  localparam logic [W-1:0]    MIDSCALE = MID32[W-1:0];

  dac_state_e   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d, per_q, per_d, ufc_q, ufc_d;
  logic [W-1:0] hold_q, hold_d, last_q, last_d, data_q, data_d;
  logic         hv_q, hv_d, dclk_q, dclk_d, uf_q, uf_d;

  logic [15:0]  per_eff, half;
  logic         period_end, start, hs;
  logic [W-1:0] fmt_smp, fmt_code;
  logic         fmt_ofs_en;
  logic         unused_cfg;

  assign per_eff       = (div < 16'(MIN_DIV)) ? 16'(MIN_DIV) : div;
  assign half          = per_q >> 1;
  assign period_end    = (state_q == ST_HIGH) && (cnt_q == per_q - 16'd1);
  assign start         = en && ((state_q == ST_IDLE) || period_end);
  assign hs            = s_axis_tvalid && !hv_q;
  assign s_axis_tready = !hv_q;
  assign unused_cfg    = ^config_dac[29:W];

  // Outside a period start the formatter produces signed zero (midscale).
  always_comb begin
    fmt_smp    = '0;
    fmt_ofs_en = 1'b0;
    if (start) begin
      if (hv_q) begin
        fmt_smp    = hold_q;
        fmt_ofs_en = config_dac[CFG_OFS_EN_BIT];
      end else if (!UNDERFLOW_ZERO) begin
        fmt_smp    = last_q;
        fmt_ofs_en = config_dac[CFG_OFS_EN_BIT];
      end
    end
  end

  dac_sat_fmt #(.DAC_DATA_WIDTH(W)) u_sat_fmt (
    .smp    (fmt_smp),
    .ofs    (config_dac[W-1:0]),
    .ofs_en (fmt_ofs_en),
    .fmt_tc (config_dac[CFG_FMT_TC_BIT]),
    .code   (fmt_code)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    last_d  = last_q;
    dclk_d  = dclk_q;
    data_d  = data_q;
    uf_d    = 1'b0;
    ufc_d   = ufc_q;
    if (hs) begin
      hv_d   = 1'b1;
      hold_d = s_axis_tdata;
    end
    if (start) begin
      state_d = ST_LOW;
      cnt_d   = '0;
      per_d   = per_eff;
      dclk_d  = 1'b0;
      data_d  = fmt_code;
      if (hv_q) begin
        hv_d   = 1'b0;
        last_d = hold_q;
      end else begin
        uf_d = 1'b1;
        if (ufc_q != 16'hFFFF) ufc_d = ufc_q + 16'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          dclk_d = 1'b0;
          data_d = fmt_code;
        end
        ST_LOW: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == half - 16'd1) begin
            state_d = ST_HIGH;
            dclk_d  = 1'b1;
          end
        end
        ST_HIGH: begin
          // Reaching the end with en low: the period is done, go quiet.
          if (period_end) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dclk_d  = 1'b0;
            data_d  = fmt_code;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      per_q   <= 16'(MIN_DIV);
      hold_q  <= '0;
      hv_q    <= 1'b0;
      last_q  <= '0;
      dclk_q  <= 1'b0;
      data_q  <= MIDSCALE;
      uf_q    <= 1'b0;
      ufc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      last_q  <= last_d;
      dclk_q  <= dclk_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
      ufc_q   <= ufc_d;
    end
  end

  assign dac_clk       = dclk_q;
  assign dac_data      = data_q;
  assign underflow     = uf_q;
  assign underflow_cnt = ufc_q;
endmodule

// File: tb/tb_ad_9708_tx.sv
// Bench for ad_9708_tx: directed scenarios plus randomized traffic, all checked
// every cycle against a period-level reference model.
module tb_ad_9708_tx;
  localparam int W  = 12;
  localparam bit UZ = 1'b0;
  localparam logic [W-1:0] MID = 12'h800;

  logic         clk = 1'b0;
  logic         rst, en, s_axis_tvalid, s_axis_tready, dac_clk, underflow;
  logic [15:0]  div, underflow_cnt;
  logic [31:0]  config_dac;
  logic [W-1:0] s_axis_tdata, dac_data;

  always #5 clk = ~clk;

  ad_9708_tx #(.DAC_DATA_WIDTH(W), .UNDERFLOW_ZERO(UZ)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .config_dac(config_dac),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .dac_clk(dac_clk), .dac_data(dac_data), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed arithmetic on plain integers, clamp, then re-bias.
  function automatic logic [W-1:0] ref_code(input logic [W-1:0] s, input logic [31:0] cfg);
    int v, o;
    v = $signed(s);
    o = $signed(cfg[W-1:0]);
    if (cfg[31]) v = v + o;
    if (v >  (1 << (W-1)) - 1) v = (1 << (W-1)) - 1;
    if (v < -(1 << (W-1)))     v = -(1 << (W-1));
    if (!cfg[30]) v = v + (1 << (W-1));
    return v[W-1:0];
  endfunction

  // Model state: position inside the current period, not an FSM encoding.
  bit           m_run, m_hv, m_uf, m_clk, m_bnd;
  int           m_i, m_P = 2, m_ufc;
  logic [W-1:0] m_hd, m_last, m_data;

  bit           rst_s, en_s, tv_s, tr_s, rand_mode;
  logic [15:0]  div_s;
  logic [31:0]  cfg_s;
  logic [W-1:0] td_s;

  logic [W-1:0] src_q[$], bnd_q[$];
  int           lo_q[$], hi_q[$];
  int           lo, hi, uf_seen;

  task automatic feed();
    s_axis_tvalid = (src_q.size() > 0);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  task automatic step();
    bit hs, end_p;
    rst_s = rst; en_s = en; div_s = div; cfg_s = config_dac;
    tv_s = s_axis_tvalid; td_s = s_axis_tdata; tr_s = s_axis_tready;
    @(posedge clk);
    hs    = tv_s && !m_hv;
    end_p = m_run && (m_i == m_P - 1);
    m_bnd = 1'b0;
    m_uf  = 1'b0;
    if (rst_s) begin
      m_run = 0; m_i = 0; m_P = 2; m_hv = 0; m_hd = '0; m_last = '0;
      m_data = MID; m_ufc = 0; hs = 0;
    end else if (en_s && (!m_run || end_p)) begin
      m_bnd = 1; m_run = 1; m_i = 0;
      m_P = (div_s < 2) ? 2 : int'(div_s);
      if (m_hv) begin
        m_data = ref_code(m_hd, cfg_s); m_last = m_hd; m_hv = 0;
      end else begin
        m_uf = 1;
        if (m_ufc < 65535) m_ufc++;
        m_data = UZ ? ref_code('0, cfg_s & 32'h7FFF_FFFF) : ref_code(m_last, cfg_s);
      end
    end else if (!m_run || end_p) begin
      m_run = 0; m_i = 0;
      m_data = ref_code('0, cfg_s & 32'h7FFF_FFFF);
    end else begin
      m_i++;
    end
    if (hs) begin m_hv = 1; m_hd = td_s; end
    m_clk = m_run && (m_i >= m_P / 2);
    #1;
    chk("tready",  s_axis_tready, !m_hv);
    chk("dac_clk", dac_clk, m_clk);
    chk("dac_data", dac_data, m_data);
    chk("underflow", underflow, m_uf);
    chk("uf_cnt", underflow_cnt, m_ufc);
    if (m_bnd) begin
      bnd_q.push_back(dac_data); lo_q.push_back(lo); hi_q.push_back(hi);
      lo = 0; hi = 0;
    end
    if (dac_clk) hi++; else lo++;
    if (underflow) uf_seen++;
    if (!rand_mode) begin
      if (src_q.size() > 0 && tv_s && tr_s) void'(src_q.pop_front());
      feed();
    end
  endtask

  task automatic clr();
    bnd_q.delete(); lo_q.delete(); hi_q.delete();
    lo = 0; hi = 0; uf_seen = 0;
  endtask

  task automatic run_bnd(input int n);
    int k = 0;
    while (bnd_q.size() < n && k < 2000) begin step(); k++; end
    chk("bnd_timeout", bnd_q.size() >= n, 1'b1);
  endtask

  task automatic go_idle();
    int k = 0;
    en = 1'b0;
    while (m_run && k < 200) begin step(); k++; end
    chk("idle_timeout", m_run, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; src_q.delete(); feed();
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rand_mode = 0;
    rst = 1'b1; en = 1'b0; div = 16'd4; config_dac = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    step();
    chk("rst_data", dac_data, 12'h800);
    chk("rst_clk", dac_clk, 1'b0);
    chk("rst_ready", s_axis_tready, 1'b1);
    chk("rst_ucnt", underflow_cnt, 16'd0);

    // Three samples streamed at div=4, offset-binary.
    do_reset(); div = 16'd4; config_dac = '0;
    src_q = '{12'h000, 12'h7FF, 12'h800}; feed();
    step(); step(); clr(); en = 1'b1;
    run_bnd(4);
    chk("s32_d0", bnd_q[0], 12'h800);
    chk("s32_d1", bnd_q[1], 12'hFFF);
    chk("s32_d2", bnd_q[2], 12'h000);
    chk("s32_lo", lo_q[1], 2);
    chk("s32_hi", hi_q[1], 2);

    // Odd period and degenerate divider.
    go_idle(); div = 16'd5; clr(); en = 1'b1;
    run_bnd(3);
    chk("s33_lo5", lo_q[1], 2);
    chk("s33_hi5", hi_q[1], 3);
    go_idle(); div = 16'd0; clr(); en = 1'b1;
    run_bnd(3);
    chk("s33_lo0", lo_q[1], 1);
    chk("s33_hi0", hi_q[1], 1);

    // Offset saturation in both directions.
    go_idle(); div = 16'd4; config_dac = 32'h8000_0100;
    src_q = '{12'h7F0}; feed(); step(); step(); clr(); en = 1'b1;
    run_bnd(1);
    chk("s34_pos", bnd_q[0], 12'hFFF);
    go_idle(); config_dac = 32'h8000_0F00;
    src_q = '{12'h880}; feed(); step(); step(); clr(); en = 1'b1;
    run_bnd(1);
    chk("s34_neg", bnd_q[0], 12'h000);

    // Underflow repeats the last sample, two's complement.
    do_reset(); div = 16'd3; config_dac = 32'h4000_0000;
    src_q = '{12'h123}; feed(); step(); step(); clr(); en = 1'b1;
    run_bnd(4);
    chk("s35_d1", bnd_q[1], 12'h123);
    chk("s35_d3", bnd_q[3], 12'h123);
    chk("s35_pulses", uf_seen, 3);
    chk("s35_ucnt", underflow_cnt, 16'd3);

    // en drop at count 1 finishes the period; reset mid-HIGH.
    do_reset(); div = 16'd8; config_dac = '0; clr(); en = 1'b1;
    run_bnd(1); step();
    en = 1'b0; n = 0;
    while (m_run && n < 50) begin step(); n++; end
    chk("s36_len", n, 7);
    chk("s36_clk", dac_clk, 1'b0);
    chk("s36_mid", dac_data, 12'h800);
    src_q = '{12'h555, 12'h2AA}; feed(); clr(); en = 1'b1;
    run_bnd(1);
    n = 0;
    while (m_i != 5 && n < 50) begin step(); n++; end
    chk("s36_high", dac_clk, 1'b1);
    chk("s36_held", s_axis_tready, 1'b0);
    rst = 1'b1; src_q.delete(); feed(); step(); rst = 1'b0;
    chk("s36_rdata", dac_data, 12'h800);
    chk("s36_rclk", dac_clk, 1'b0);
    chk("s36_ruf", underflow, 1'b0);
    chk("s36_rucnt", underflow_cnt, 16'd0);
    chk("s36_rready", s_axis_tready, 1'b1);

    // Randomized traffic.
    rand_mode = 1; en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0)  div = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 149) == 0) config_dac = $urandom;
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      s_axis_tdata  = W'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
